hazard_pc_ctrl: RTL and testbench

Pipeline hazard and next-PC controller for the 5-stage MIPS core. Each cycle it computes the PC register's next value and stall input, plus the IF/ID and ID/EX stall, flush and bubble controls. It covers load-use interlocks, ID-stage branch/jump redirects (no delay slot) and the multi-cycle multiply/divide unit's busy window. It sits beside the PC register and drives its `pc_in` and `stall` pins; it also keeps a saturating stall-cycle counter.

---
 rtl/hazard_pc_ctrl_pkg.sv | 19 +
 rtl/md_busy_timer.sv | 58 +++++
 rtl/hazard_pc_ctrl.sv | 98 +++++++++
 tb/tb_hazard_pc_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pc_ctrl_pkg.sv
// Shared types and constants for the hazard / next-PC controller and its
// multiply/divide busy timer.
package hazard_pc_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Wide enough for a load value of LATENCY-1 with LATENCY up to 64.
  localparam int MD_CNT_W = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Tracks how long the multiply/divide unit stays occupied after an accepted
// start: a two-state FSM plus a down-counter loaded with LATENCY-1.
module md_busy_timer
  import hazard_pc_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic md_accept,
  input  logic md_is_div,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_LATENCY - 1);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_LATENCY - 1);

  md_state_e             state, state_next;
  logic [MD_CNT_W-1:0]   md_cnt, md_cnt_next;

  // NOTE: non-blocking assignments in always_ff so every register updates
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else if (ena) begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // NOTE: every always_comb output gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    unique case (state)
      MD_IDLE: begin
        if (md_accept) begin
          state_next  = MD_RUN;
          md_cnt_next = md_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_RUN: begin
        // A new accept cannot land here: the hazard logic blocks it while busy.
        if (md_cnt == '0) state_next = MD_IDLE;
        else              md_cnt_next = md_cnt - 1'b1;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  assign md_busy = (state == MD_RUN);

endmodule

// File: rtl/hazard_pc_ctrl.sv
// Hazard detection and next-PC selection for the 5-stage MIPS pipeline:
// load-use interlock, ID-stage redirects and mult/div busy stalls.
module hazard_pc_ctrl
  import hazard_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          MUL_LATENCY = 4,
  parameter int          DIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] pc_cur,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_target,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        id_md_start,
  input  logic        id_md_is_div,
  input  logic        id_hilo_read,
  output logic [31:0] pc_next,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic        md_accept,
  output logic [31:0] stall_cnt
);

  logic rs_match, rt_match;
  logic load_hz, md_hz, hz;

  assign rs_match = id_use_rs && (id_rs == ex_rd);
  assign rt_match = id_use_rt && (id_rt == ex_rd);
  // $zero is never a real dependency, even if a load names it.
  assign load_hz  = ex_mem_read && (ex_rd != 5'd0) && (rs_match || rt_match);
  assign md_hz    = md_busy && (id_hilo_read || id_md_start);
  assign hz       = load_hz || md_hz;

  always_comb begin
    pc_next     = pc_cur;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_accept   = 1'b0;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (!ena) begin
      // Frozen pipeline: hold PC and IF/ID without disturbing ID/EX.
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (hz) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      md_accept = id_md_start;
      if (id_jump) begin
        pc_next    = id_jump_target;
        ifid_flush = 1'b1;
      end else if (id_branch_taken) begin
        pc_next    = id_branch_target;
        ifid_flush = 1'b1;
      end else begin
        pc_next = seq_pc(pc_cur);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ena && pc_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  md_busy_timer #(
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_md_timer (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .md_accept (md_accept),
    .md_is_div (id_md_is_div),
    .md_busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_pc_ctrl.sv
// Self-checking bench for hazard_pc_ctrl: directed scenarios plus randomized
// traffic compared against a cycles-remaining behavioural model.
module tb_hazard_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          MUL_LAT  = 4;
  localparam int          DIV_LAT  = 32;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [31:0] pc_cur;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, ex_mem_read;
  logic        id_branch_taken, id_jump;
  logic [31:0] id_branch_target, id_jump_target;
  logic        id_md_start, id_md_is_div, id_hilo_read;
  logic [31:0] pc_next, stall_cnt;
  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, md_busy, md_accept;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: cycles of busy time left, and the stall count.
  int unsigned     m_busy_left = 0;
  longint unsigned m_stall_cnt = 0;

  logic [31:0] exp_pc_next, exp_stall_cnt;
  logic        exp_pc_stall, exp_ifid_stall, exp_ifid_flush, exp_idex_bubble;
  logic        exp_md_busy, exp_md_accept, exp_pc_valid;

  always #5 clk = ~clk;

  hazard_pc_ctrl #(
    .RESET_PC    (RESET_PC),
    .MUL_LATENCY (MUL_LAT),
    .DIV_LATENCY (DIV_LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ena              (ena),
    .pc_cur           (pc_cur),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_use_rs        (id_use_rs),
    .id_use_rt        (id_use_rt),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .id_branch_taken  (id_branch_taken),
    .id_branch_target (id_branch_target),
    .id_jump          (id_jump),
    .id_jump_target   (id_jump_target),
    .id_md_start      (id_md_start),
    .id_md_is_div     (id_md_is_div),
    .id_hilo_read     (id_hilo_read),
    .pc_next          (pc_next),
    .pc_stall         (pc_stall),
    .ifid_stall       (ifid_stall),
    .ifid_flush       (ifid_flush),
    .idex_bubble      (idex_bubble),
    .md_busy          (md_busy),
    .md_accept        (md_accept),
    .stall_cnt        (stall_cnt)
  );

  // Expected outputs for the current inputs and model state.
  task automatic model_eval();
    logic lhz, mhz;
    lhz = ex_mem_read && (ex_rd != 5'd0) &&
          ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    mhz = (m_busy_left != 0) && (id_hilo_read || id_md_start);
    exp_md_busy     = (m_busy_left != 0);
    exp_stall_cnt   = m_stall_cnt[31:0];
    exp_pc_stall    = 1'b0;
    exp_ifid_stall  = 1'b0;
    exp_ifid_flush  = 1'b0;
    exp_idex_bubble = 1'b0;
    exp_md_accept   = 1'b0;
    exp_pc_valid    = 1'b1;
    exp_pc_next     = pc_cur + 32'd4;
    if (rst) begin
      exp_pc_next = RESET_PC;
    end else if (!ena) begin
      exp_pc_stall   = 1'b1;
      exp_ifid_stall = 1'b1;
      exp_pc_valid   = 1'b0;
    end else if (lhz || mhz) begin
      exp_pc_stall    = 1'b1;
      exp_ifid_stall  = 1'b1;
      exp_idex_bubble = 1'b1;
      exp_pc_valid    = 1'b0;
    end else begin
      exp_md_accept = id_md_start;
      if (id_jump) begin
        exp_pc_next    = id_jump_target;
        exp_ifid_flush = 1'b1;
      end else if (id_branch_taken) begin
        exp_pc_next    = id_branch_target;
        exp_ifid_flush = 1'b1;
      end
    end
  endtask

  // Advance one clock edge, updating the model with what that edge does.
  task automatic cycle();
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_busy_left = 0;
      m_stall_cnt = 0;
    end else if (ena) begin
      if (exp_pc_stall && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (exp_md_accept)        m_busy_left = id_md_is_div ? DIV_LAT : MUL_LAT;
      else if (m_busy_left != 0) m_busy_left--;
    end
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic clear_inputs();
    ena = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0;
    id_branch_taken = 1'b0; id_jump = 1'b0;
    id_branch_target = 32'h0; id_jump_target = 32'h0;
    id_md_start = 1'b0; id_md_is_div = 1'b0; id_hilo_read = 1'b0;
    pc_cur = 32'h0040_0000;
  endtask

  task automatic drain();
    clear_inputs();
    for (int i = 0; i < 100 && m_busy_left != 0; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    id_md_start = 1'b1; id_jump = 1'b1; id_jump_target = 32'h1234_5678;
    settle();
    n_tests++;
    if (pc_next !== RESET_PC || pc_stall !== 1'b0 || ifid_stall !== 1'b0 ||
        ifid_flush !== 1'b0 || idex_bubble !== 1'b0 || md_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got pc=%h st=%b%b fl=%b bb=%b acc=%b exp pc=%h others 0",
               pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble, md_accept, RESET_PC);
    end
    n_tests++;
    if (md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b cnt=%0d exp 0/0", md_busy, stall_cnt);
    end
    rst = 1'b0;
    clear_inputs();
    cycle();
  endtask

  task automatic test_load_use();
    pc_cur = 32'h0040_0008;
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    settle();
    n_tests++;
    if (pc_stall !== 1'b1 || ifid_stall !== 1'b1 || idex_bubble !== 1'b1 ||
        ifid_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_stall got st=%b ifst=%b bb=%b fl=%b exp 1/1/1/0",
               pc_stall, ifid_stall, idex_bubble, ifid_flush);
    end
    cycle();
    ex_mem_read = 1'b0;
    settle();
    n_tests++;
    if (pc_stall !== 1'b0 || stall_cnt !== 32'd1 || pc_next !== 32'h0040_000C) begin
      n_fail++;
      $display("FAIL load_use_after got st=%b cnt=%0d pc=%h exp 0/1/0040000c",
               pc_stall, stall_cnt, pc_next);
    end
    cycle();
  endtask

  task automatic test_rd_zero();
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    id_rt = 5'd0; id_use_rt = 1'b1;
    settle();
    n_tests++;
    if (pc_stall !== 1'b0 || idex_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_zero got st=%b bb=%b exp 0/0", pc_stall, idex_bubble);
    end
    cycle();
  endtask

  task automatic test_branch();
    clear_inputs();
    pc_cur = 32'h0040_0010;
    id_branch_taken = 1'b1; id_branch_target = 32'h0040_0040;
    settle();
    n_tests++;
    if (pc_next !== 32'h0040_0040 || ifid_flush !== 1'b1 || pc_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_taken got pc=%h fl=%b st=%b exp 00400040/1/0",
               pc_next, ifid_flush, pc_stall);
    end
    cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_use_rt = 1'b1;
    settle();
    n_tests++;
    if (pc_stall !== 1'b1 || ifid_flush !== 1'b0 || idex_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_with_load got st=%b fl=%b bb=%b exp 1/0/1",
               pc_stall, ifid_flush, idex_bubble);
    end
    cycle();
    clear_inputs();
    pc_cur = 32'h0040_0010;
    id_jump = 1'b1; id_jump_target = 32'h0080_0000;
    id_branch_taken = 1'b1; id_branch_target = 32'h0040_0040;
    settle();
    n_tests++;
    if (pc_next !== 32'h0080_0000 || ifid_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_priority got pc=%h fl=%b exp 00800000/1", pc_next, ifid_flush);
    end
    cycle();
  endtask

  task automatic test_wrap();
    clear_inputs();
    pc_cur = 32'hFFFF_FFFC;
    settle();
    n_tests++;
    if (pc_next !== 32'h0000_0000 || ifid_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL pc_wrap got pc=%h fl=%b exp 00000000/0", pc_next, ifid_flush);
    end
    cycle();
  endtask

  task automatic test_div_busy();
    int busy_cycles;
    drain();
    id_md_start = 1'b1; id_md_is_div = 1'b1;
    settle();
    n_tests++;
    if (md_accept !== 1'b1 || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div_accept got acc=%b busy=%b exp 1/0", md_accept, md_busy);
    end
    cycle();
    id_md_start = 1'b0; id_hilo_read = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (md_busy !== 1'b1) break;
      busy_cycles++;
      n_tests++;
      if (pc_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL div_hilo_stall cyc=%0d got st=%b exp 1", busy_cycles, pc_stall);
      end
      cycle();
    end
    n_tests++;
    if (busy_cycles != DIV_LAT) begin
      n_fail++;
      $display("FAIL div_busy_len got %0d cycles exp %0d", busy_cycles, DIV_LAT);
    end
    n_tests++;
    if (pc_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL div_stall_release got st=%b exp 0", pc_stall);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    drain();
    id_md_start = 1'b1; id_md_is_div = 1'b0;
    settle();
    n_tests++;
    if (md_accept !== 1'b1) begin
      n_fail++;
      $display("FAIL mult_first_accept got acc=%b exp 1", md_accept);
    end
    cycle();
    for (int k = 0; k < MUL_LAT; k++) begin
      settle();
      n_tests++;
      if (md_accept !== 1'b0 || pc_stall !== 1'b1 || md_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL mult_second_held k=%0d got acc=%b st=%b busy=%b exp 0/1/1",
                 k, md_accept, pc_stall, md_busy);
      end
      cycle();
    end
    settle();
    n_tests++;
    if (md_accept !== 1'b1 || md_busy !== 1'b0 || pc_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_second_accept got acc=%b busy=%b st=%b exp 1/0/0",
               md_accept, md_busy, pc_stall);
    end
    cycle();
    id_md_start = 1'b0;
    settle();
    n_tests++;
    if (md_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mult_rebusy got busy=%b exp 1", md_busy);
    end
    cycle();
  endtask

  task automatic test_rst_mid_run();
    drain();
    id_md_start = 1'b1; id_md_is_div = 1'b1;
    settle();
    cycle();
    clear_inputs();
    repeat (3) cycle();
    #2;
    rst = 1'b1;
    m_busy_left = 0;
    m_stall_cnt = 0;
    #1;
    n_tests++;
    if (md_busy !== 1'b0 || pc_next !== RESET_PC || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_run got busy=%b pc=%h cnt=%0d exp 0/%h/0",
               md_busy, pc_next, stall_cnt, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_enable();
    drain();
    id_md_start = 1'b1; id_md_is_div = 1'b0;
    settle();
    cycle();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_tests++;
      if (pc_stall !== 1'b1 || ifid_stall !== 1'b1 || idex_bubble !== 1'b0 ||
          ifid_flush !== 1'b0 || md_accept !== 1'b0 || md_busy !== 1'b1 ||
          stall_cnt !== exp_stall_cnt) begin
        n_fail++;
        $display("FAIL ena_freeze k=%0d got st=%b%b bb=%b fl=%b acc=%b busy=%b cnt=%0d exp 11/0/0/0/1/%0d",
                 k, pc_stall, ifid_stall, idex_bubble, ifid_flush, md_accept, md_busy,
                 stall_cnt, exp_stall_cnt);
      end
      cycle();
    end
    ena = 1'b1; id_md_start = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) cycle();
    settle();
    n_tests++;
    if (md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ena_resume got busy=%b exp 0 after %0d enabled cycles", md_busy, MUL_LAT);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ena              = ($urandom_range(0, 9) != 0);
      pc_cur           = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      id_rs            = 5'($urandom_range(0, 3));
      id_rt            = 5'($urandom_range(0, 3));
      ex_rd            = 5'($urandom_range(0, 3));
      id_use_rs        = 1'($urandom_range(0, 1));
      id_use_rt        = 1'($urandom_range(0, 1));
      ex_mem_read      = ($urandom_range(0, 2) == 0);
      id_branch_taken  = 1'($urandom_range(0, 1));
      id_branch_target = $urandom;
      id_jump          = ($urandom_range(0, 3) == 0);
      id_jump_target   = $urandom;
      id_md_start      = ($urandom_range(0, 5) == 0);
      id_md_is_div     = ($urandom_range(0, 3) == 0);
      id_hilo_read     = ($urandom_range(0, 3) == 0);
      settle();
      n_tests++;
      if (pc_stall !== exp_pc_stall || ifid_stall !== exp_ifid_stall ||
          ifid_flush !== exp_ifid_flush || idex_bubble !== exp_idex_bubble ||
          md_accept !== exp_md_accept || md_busy !== exp_md_busy ||
          stall_cnt !== exp_stall_cnt || (exp_pc_valid && pc_next !== exp_pc_next)) begin
        n_fail++;
        $display("FAIL rand c=%0d got st=%b%b fl=%b bb=%b acc=%b busy=%b cnt=%0d pc=%h exp st=%b%b fl=%b bb=%b acc=%b busy=%b cnt=%0d pc=%h(chk=%b)",
                 c, pc_stall, ifid_stall, ifid_flush, idex_bubble, md_accept, md_busy,
                 stall_cnt, pc_next, exp_pc_stall, exp_ifid_stall, exp_ifid_flush,
                 exp_idex_bubble, exp_md_accept, exp_md_busy, exp_stall_cnt,
                 exp_pc_next, exp_pc_valid);
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch();
    test_wrap();
    test_div_busy();
    test_back_to_back();
    test_rst_mid_run();
    test_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
